// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the frame-bank state encoding,
// common to the frame buffer and the downstream FFT stages.
package fft_pkg;

    localparam int FFT_DATA_W = 32;
    localparam int FFT_N_PTS  = 8;
    localparam int FFT_CNT_W  = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Sample-in / frame-out handshake bundle between the sample source,
// the frame buffer and the downstream FFT.
interface fft_frame_buffer_if
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W
);

    logic signed [DATA_W-1:0]    samp_data;
    logic                        samp_valid;
    logic                        samp_ready;
    logic                        sync_clr;
    logic signed [DATA_W-1:0]    x0;
    logic signed [DATA_W-1:0]    x1;
    logic signed [DATA_W-1:0]    x2;
    logic signed [DATA_W-1:0]    x3;
    logic signed [DATA_W-1:0]    x4;
    logic signed [DATA_W-1:0]    x5;
    logic signed [DATA_W-1:0]    x6;
    logic signed [DATA_W-1:0]    x7;
    logic                        frame_valid;
    logic                        frame_ready;
    logic [FFT_CNT_W-1:0]        frame_cnt;

    modport master (
        output samp_data, samp_valid, sync_clr, frame_ready,
        input  samp_ready, frame_valid, frame_cnt,
        input  x0, x1, x2, x3, x4, x5, x6, x7
    );

    modport slave (
        input  samp_data, samp_valid, sync_clr, frame_ready,
        output samp_ready, frame_valid, frame_cnt,
        output x0, x1, x2, x3, x4, x5, x6, x7
    );

endinterface

// File: rtl/fft_frame_buffer_bank.sv
// One ping-pong half: N_PTS x DATA_W register bank with indexed write
// and full parallel read.
module frame_bank
    import fft_pkg::*;
#(
    parameter  int DATA_W = FFT_DATA_W,
    parameter  int N_PTS  = FFT_N_PTS,
    localparam int IDX_W  = $clog2(N_PTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_wr_en,
    input  logic [IDX_W-1:0]               i_wr_idx,
    input  logic [DATA_W-1:0]              i_wr_data,
    output logic [N_PTS-1:0][DATA_W-1:0]   o_rd_data
);

    logic [N_PTS-1:0][DATA_W-1:0] r_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem;

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer: collects 8 consecutive samples into one bank
// while the other bank is presented in parallel to the FFT.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int N_PTS  = FFT_N_PTS
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_frame_buffer_if.slave  bus
);

    localparam int IDX_W = $clog2(N_PTS);

    bank_state_t               r_bank_st [2];
    bank_state_t               w_bank_st_nxt [2];
    logic                      r_wr_sel;
    logic                      w_wr_sel_nxt;
    logic                      r_rd_sel;
    logic                      w_rd_sel_nxt;
    logic [IDX_W-1:0]          r_wr_idx;
    logic [IDX_W-1:0]          w_wr_idx_nxt;
    logic [FFT_CNT_W-1:0]      r_frame_cnt;
    logic [FFT_CNT_W-1:0]      w_frame_cnt_nxt;
    logic                      r_run;

    logic                      w_samp_ready;
    logic                      w_frame_valid;
    logic                      w_accept;
    logic                      w_consume;
    logic                      w_wr_en0;
    logic                      w_wr_en1;
    logic [N_PTS-1:0][DATA_W-1:0] w_bank0_rd;
    logic [N_PTS-1:0][DATA_W-1:0] w_bank1_rd;
    logic [N_PTS-1:0][DATA_W-1:0] w_rd_frame;

    assign w_accept  = bus.samp_valid & w_samp_ready;
    assign w_consume = w_frame_valid & bus.frame_ready;
    assign w_wr_en0  = w_accept & ~r_wr_sel;
    assign w_wr_en1  = w_accept &  r_wr_sel;

    frame_bank #(
        .DATA_W (DATA_W),
        .N_PTS  (N_PTS)
    ) u_bank0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en0),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (bus.samp_data),
        .o_rd_data (w_bank0_rd)
    );

    frame_bank #(
        .DATA_W (DATA_W),
        .N_PTS  (N_PTS)
    ) u_bank1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en1),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (bus.samp_data),
        .o_rd_data (w_bank1_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_st[0] <= BANK_EMPTY;
            r_bank_st[1] <= BANK_EMPTY;
            r_wr_sel     <= 1'b0;
            r_rd_sel     <= 1'b0;
            r_wr_idx     <= '0;
            r_frame_cnt  <= '0;
            r_run        <= 1'b0;
        end else begin
            r_bank_st[0] <= w_bank_st_nxt[0];
            r_bank_st[1] <= w_bank_st_nxt[1];
            r_wr_sel     <= w_wr_sel_nxt;
            r_rd_sel     <= w_rd_sel_nxt;
            r_wr_idx     <= w_wr_idx_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_run        <= 1'b1;
        end
    end

    // Completion and consume never target the same bank: the write bank
    // equals a FULL read bank only when both are FULL and writes are stalled.
    always_comb begin
        w_bank_st_nxt   = r_bank_st;
        w_wr_sel_nxt    = r_wr_sel;
        w_rd_sel_nxt    = r_rd_sel;
        w_wr_idx_nxt    = r_wr_idx;
        w_frame_cnt_nxt = r_frame_cnt;

        if (bus.sync_clr) begin
            w_wr_idx_nxt = '0;
            if (r_bank_st[r_wr_sel] == BANK_FILLING) begin
                w_bank_st_nxt[r_wr_sel] = BANK_EMPTY;
            end
        end else if (w_accept) begin
            if (r_wr_idx == IDX_W'(N_PTS - 1)) begin
                w_bank_st_nxt[r_wr_sel] = BANK_FULL;
                w_wr_idx_nxt            = '0;
                w_wr_sel_nxt            = ~r_wr_sel;
            end else begin
                w_bank_st_nxt[r_wr_sel] = BANK_FILLING;
                w_wr_idx_nxt            = r_wr_idx + 1'b1;
            end
        end

        if (w_consume) begin
            w_bank_st_nxt[r_rd_sel] = BANK_EMPTY;
            w_rd_sel_nxt            = ~r_rd_sel;
            w_frame_cnt_nxt         = r_frame_cnt + 1'b1;
        end
    end

    always_comb begin
        w_samp_ready  = r_run & (r_bank_st[r_wr_sel] != BANK_FULL) & ~bus.sync_clr;
        w_frame_valid = (r_bank_st[r_rd_sel] == BANK_FULL);
        w_rd_frame    = r_rd_sel ? w_bank1_rd : w_bank0_rd;
    end

    assign bus.samp_ready  = w_samp_ready;
    assign bus.frame_valid = w_frame_valid;
    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.x0          = w_rd_frame[0];
    assign bus.x1          = w_rd_frame[1];
    assign bus.x2          = w_rd_frame[2];
    assign bus.x3          = w_rd_frame[3];
    assign bus.x4          = w_rd_frame[4];
    assign bus.x5          = w_rd_frame[5];
    assign bus.x6          = w_rd_frame[6];
    assign bus.x7          = w_rd_frame[7];

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed and randomized bench for fft_frame_buffer against a
// queue-of-frames reference model.
module tb_fft_frame_buffer;
    import fft_pkg::*;

    localparam int DW = FFT_DATA_W;
    localparam int FW = 8 * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    fft_frame_buffer_if #(.DATA_W(DW)) bus ();

    fft_frame_buffer #(
        .DATA_W (DW),
        .N_PTS  (FFT_N_PTS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: completed frames awaiting consumption, the partial frame,
    // and the consumed-frame count; two frames of storage in total.
    logic [FW-1:0] pend[$];
    logic [DW-1:0] part[$];
    logic [15:0]   m_cnt = '0;
    bit            m_run = 1'b0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] dut_frame();
        return {bus.x7, bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};
    endfunction

    function automatic logic [FW-1:0] pack_part();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i*DW +: DW] = part[i];
        return f;
    endfunction

    task automatic set_idle();
        bus.samp_valid  = 1'b0;
        bus.samp_data   = '0;
        bus.sync_clr    = 1'b0;
        bus.frame_ready = 1'b0;
    endtask

    // One clock: drive, check outputs against the model, then advance the model.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit clr, input bit fr,
                        input string tag, output bit acc);
        bit exp_rdy, exp_val, con;
        @(negedge clk);
        bus.samp_valid  = v;
        bus.samp_data   = d;
        bus.sync_clr    = clr;
        bus.frame_ready = fr;
        #1;
        exp_rdy = m_run && (pend.size() < 2) && !clr;
        exp_val = (pend.size() > 0);
        chk({tag, ".samp_ready"}, FW'(bus.samp_ready), FW'(exp_rdy));
        chk({tag, ".frame_valid"}, FW'(bus.frame_valid), FW'(exp_val));
        chk({tag, ".frame_cnt"}, FW'(bus.frame_cnt), FW'(m_cnt));
        if (exp_val) chk({tag, ".frame"}, dut_frame(), pend[0]);
        acc = v && exp_rdy;
        con = exp_val && fr;
        @(posedge clk);
        if (con) begin
            void'(pend.pop_front());
            m_cnt++;
        end
        if (clr) begin
            part.delete();
        end else if (acc) begin
            part.push_back(d);
            if (part.size() == 8) begin
                pend.push_back(pack_part());
                part.delete();
            end
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        pend.delete();
        part.delete();
        m_cnt = '0;
        m_run = 1'b0;
        chk({tag, ".samp_ready"}, FW'(bus.samp_ready), '0);
        chk({tag, ".frame_valid"}, FW'(bus.frame_valid), '0);
        chk({tag, ".frame_cnt"}, FW'(bus.frame_cnt), '0);
        chk({tag, ".frame"}, dut_frame(), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, ".ready_after_release"}, FW'(bus.samp_ready), '0);
        @(posedge clk);
        m_run = 1'b1;
    endtask

    initial begin
        bit a;
        int k;
        set_idle();

        do_reset("reset");

        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b1, "first", a);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1, "first_idle", a);

        // Two frames buffered with no consumer, then a single consume.
        k = 1;
        repeat (20) begin
            step(1'b1, DW'(k), 1'b0, 1'b0, "stall", a);
            if (a) k++;
        end
        step(1'b1, DW'(k), 1'b0, 1'b1, "consume1", a);
        if (a) k++;
        repeat (3) begin
            step(1'b1, DW'(k), 1'b0, 1'b0, "resume", a);
            if (a) k++;
        end
        for (int c = 0; c < 40 && k <= 24; c++) begin
            step(1'b1, DW'(k), 1'b0, 1'b1, "drain24", a);
            if (a) k++;
        end
        repeat (4) step(1'b0, '0, 1'b0, 1'b1, "drain_idle", a);

        // Partial frame discarded by sync_clr.
        for (int i = 0; i < 3; i++) step(1'b1, DW'(50 + i), 1'b0, 1'b0, "partial", a);
        step(1'b0, '0, 1'b1, 1'b0, "sync_clr", a);
        for (int i = 100; i <= 107; i++) step(1'b1, DW'(i), 1'b0, 1'b0, "after_clr", a);
        step(1'b0, '0, 1'b0, 1'b1, "take_clr", a);
        step(1'b0, '0, 1'b0, 1'b0, "post_clr", a);

        // Valid together with sync_clr must not write.
        step(1'b1, DW'(32'hDEAD_BEEF), 1'b1, 1'b0, "valid_and_clr", a);
        for (int i = 200; i < 208; i++) step(1'b1, DW'(i), 1'b0, 1'b1, "after_vclr", a);
        repeat (2) step(1'b0, '0, 1'b0, 1'b1, "vclr_idle", a);

        // Counter wrap with completion and consume in the same cycle.
        @(negedge clk);
        set_idle();
        force dut.r_frame_cnt = 16'hFFFE;
        #1;
        release dut.r_frame_cnt;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 32; i++)
            step(1'b1, DW'(300 + i), 1'b0, (part.size() == 7), "wrap", a);
        repeat (2) step(1'b0, '0, 1'b0, 1'b1, "wrap_idle", a);

        repeat (400) begin
            step(($urandom_range(3) != 0), DW'($urandom), ($urandom_range(31) == 0),
                 ($urandom_range(2) == 0), "random", a);
        end
        repeat (4) step(1'b0, '0, 1'b0, 1'b1, "random_drain", a);

        // Reset with one frame held and five samples in flight.
        for (int i = 0; i < 13; i++) step(1'b1, DW'(500 + i), 1'b0, 1'b0, "pre_reset", a);
        do_reset("mid_reset");
        for (int i = 400; i < 408; i++) step(1'b1, DW'(i), 1'b0, 1'b1, "post_reset", a);
        repeat (2) step(1'b0, '0, 1'b0, 1'b1, "post_reset_idle", a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_buffer.md
FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample and frame word width (signed).
REQ-002 SHALL have parameter N_PTS, default 8, samples per frame; only 8 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port samp_data, input, DATA_W, signed time-domain sample.
REQ-006 SHALL have port samp_valid, input, 1, samp_data is valid.
REQ-007 SHALL have port samp_ready, output, 1, the block can accept a sample.
REQ-008 SHALL have port sync_clr, input, 1, discards the partially filled frame.
REQ-009 SHALL have ports x0..x7, output, DATA_W each, frame samples in arrival order (x0 oldest).
REQ-010 SHALL have port frame_valid, output, 1, x0..x7 hold a complete frame.
REQ-011 SHALL have port frame_ready, input, 1, the downstream FFT consumes the frame.
REQ-012 SHALL have port frame_cnt, output, 16, count of frames consumed, modulo 2^16.

Function
REQ-013 SHALL hold two banks of N_PTS words (ping-pong): one write bank, one read bank; each bank is EMPTY, FILLING or FULL.
REQ-014 SHALL accept a sample when samp_valid and samp_ready are both high in the same cycle; it then writes the sample at the 3-bit write index and increments that index.
REQ-015 SHALL drive samp_ready = (write bank not FULL) and not sync_clr.
REQ-016 SHALL, on the accept that writes index 7, mark the write bank FULL, wrap the index to 0 and toggle the write-bank select.
REQ-017 SHALL drive frame_valid high in the cycle after the 8th sample of a frame is accepted (latency 1), and keep it high while the read bank is FULL.
REQ-018 SHALL drive x0..x7 from the read bank, registered, and hold them stable while frame_valid is high and frame_ready is low.
REQ-019 SHALL, on frame_valid and frame_ready both high, mark the read bank EMPTY, toggle the read-bank select and increment frame_cnt, wrapping 0xFFFF to 0.
REQ-020 SHALL, when both banks are FULL, hold samp_ready low until a frame is consumed; samp_ready rises in the cycle after that consume.
REQ-021 SHALL handle a frame completing and a frame being consumed in the same cycle with both effects applied; samples are neither lost nor duplicated.
REQ-022 SHALL, on sync_clr high, reset the write index to 0 and return a FILLING write bank to EMPTY.
REQ-023 SHALL keep FULL banks and frame_valid unchanged by sync_clr.
REQ-024 SHALL NOT accept a sample in any cycle where sync_clr is high.
REQ-025 SHALL pass sample values unmodified: no scaling, saturation or reordering.
REQ-026 SHALL deliver frames in completion order, and no frame SHALL be presented twice.

Reset
REQ-027 SHALL, while rst_n is low, set samp_ready=0, frame_valid=0, x0..x7=0, frame_cnt=0, both banks EMPTY, both selects=bank 0 and write index=0.
REQ-028 SHALL raise samp_ready in the first clock edge after rst_n deasserts.
REQ-029 SHALL discard any partial or unconsumed frame when reset occurs mid-operation.

Structure
REQ-030 SHALL take DATA_W, N_PTS and the bank-state encoding (EMPTY/FILLING/FULL) from a shared package fft_pkg, which the FFT stages also use.
REQ-031 SHALL have at most one sub-module, frame_bank (an 8 x DATA_W register bank with write-enable, 3-bit write index and parallel read), instantiated twice.

Verification
REQ-032 Reset then send samples 1..8 back-to-back with frame_ready=1 -> frame_valid pulses one cycle after sample 8; x0..x7=1..8; frame_cnt=1.
REQ-033 Hold frame_ready=0 and send 24 samples -> two frames buffered; samp_ready low after sample 16; first frame (1..8) stays stable; one consume raises samp_ready the next cycle; frames come out 1..8 then 9..16.
REQ-034 Send 3 samples, pulse sync_clr, then send 100..107 -> the frame presented is 100..107 and frame_cnt increments by 1.
REQ-035 Drive samp_valid and sync_clr high together -> no write occurs and the write index stays 0.
REQ-036 Consume a frame in the same cycle another frame completes -> no stall, no lost sample; frame_cnt continues from 0xFFFF to 0x0000 across the wrap (frame_cnt preloaded via 65535 frames, or forced).
REQ-037 Assert rst_n low mid-frame (after 5 samples, one frame FULL) -> all outputs go to their reset values asynchronously, and the next 8 samples form frame 1.
